data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time with fixed latency.
// Ports: Clk/Reset, Req* valid/ready request, Rsp* valid/ready response.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqType,
  input  logic        ReqUnsigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspRData,
  output logic        RspError
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  type_q, type_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic [31:0]   ld_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          err;
  logic          commit;
  logic          mem_we;
  logic          unused_addr;

  // Upper address bits fall outside the array and wrap.
  assign idx         = addr_q[AW+1:2];
  assign unused_addr = ^addr_q[31:AW+2];
  assign rd_word     = mem[idx];

  assign ReqReady = (state_q == IDLE);
  assign RspValid = rsp_valid_q;
  assign RspRData = rsp_rdata_q;
  assign RspError = rsp_error_q;

  always_comb begin
    err     = 1'b0;
    ld_data = 32'h0;
    wr_word = rd_word;
    ld_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (type_q)
      2'b00: begin
        err     = (addr_q[1:0] != 2'b00);
        ld_data = rd_word;
        wr_word = wdata_q;
      end
      2'b01: begin
        err     = addr_q[0];
        ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
        wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      2'b10: begin
        ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
        wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      default: err = 1'b1;
    endcase
  end

  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);
  // A reset on the commit edge abandons the store.
  assign mem_we = commit & write_q & ~err & ~Reset;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    type_d      = type_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    unique case (state_q)
      IDLE: begin
        if (ReqValid) begin
          write_d = ReqWrite;
          type_d  = ReqType;
          uns_d   = ReqUnsigned;
          addr_d  = ReqAddr;
          wdata_d = ReqWData;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_error_d = err;
          rsp_rdata_d = (write_q || err) ? 32'h0 : ld_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (RspReady) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_error_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      type_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      type_q      <= type_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[idx] <= wr_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY=2, DEPTH_WORDS=1024).
// Each task drives one scenario and checks its own expected values.
module tb_data_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqType;
  logic        ReqUnsigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspRData;
  logic        RspError;

  int vectors = 0;
  int miscompares = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqType(ReqType),
    .ReqUnsigned(ReqUnsigned), .ReqAddr(ReqAddr),
    .ReqWData(ReqWData),
    .RspValid(RspValid), .RspReady(RspReady),
    .RspRData(RspRData), .RspError(RspError)
  );

  always #5 Clk = ~Clk;

  // One full transaction from IDLE; lat = edges from accept to RspValid.
  task automatic xact(input logic w, input logic [1:0] t,
                      input logic u, input logic [31:0] a,
                      input logic [31:0] d,
                      output logic [31:0] rd, output logic e,
                      output int lat);
    ReqWrite = w; ReqType = t; ReqUnsigned = u;
    ReqAddr = a; ReqWData = d;
    ReqValid = 1'b1; RspReady = 1'b1;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    lat = 0;
    while (!RspValid && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    rd = RspRData;
    e  = RspError;
    if (!RspValid) begin
      vectors++; miscompares++;
      $display("FAIL xact_timeout addr=%h got no RspValid, required 1", a);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0;
    ReqType = 2'b00; ReqUnsigned = 1'b0;
    ReqAddr = 32'h0; ReqWData = 32'h0; RspReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    vectors++;
    if (ReqReady !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_req_ready got %b required 1", ReqReady);
    end
    vectors++;
    if (RspValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rsp_valid got %b required 0", RspValid);
    end
    vectors++;
    if (RspRData !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rsp_rdata got %h required 0", RspRData);
    end
    vectors++;
    if (RspError !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rsp_error got %b required 0", RspError);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, rd, e, lat);
    vectors++;
    if ({e, rd} !== 33'h0) begin
      miscompares++;
      $display("FAIL word_store_rsp got e=%b rd=%h required 0/0", e, rd);
    end
    xact(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, e, lat);
    vectors++;
    if (lat + 1 !== 3) begin
      miscompares++;
      $display("FAIL word_load_latency got %0d required 3", lat + 1);
    end
    vectors++;
    if (rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL word_load_data got %h required deadbeef", rd);
    end
    vectors++;
    if (e !== 1'b0) begin
      miscompares++;
      $display("FAIL word_load_error got %b required 0", e);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 2'b10, 1'b0, 32'h13, 32'h80, rd, e, lat);
    xact(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, rd, e, lat);
    vectors++;
    if (rd !== 32'hFFFFFF80) begin
      miscompares++;
      $display("FAIL byte_signed got %h required ffffff80", rd);
    end
    xact(1'b0, 2'b10, 1'b1, 32'h13, 32'h0, rd, e, lat);
    vectors++;
    if (rd !== 32'h00000080) begin
      miscompares++;
      $display("FAIL byte_unsigned got %h required 00000080", rd);
    end
    xact(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, e, lat);
    vectors++;
    if (rd !== 32'h80ADBEEF) begin
      miscompares++;
      $display("FAIL byte_merge_word got %h required 80adbeef", rd);
    end
  endtask

  task automatic test_half_errors();
    logic [31:0] rd; logic e; int lat;
    xact(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, e, lat);
    vectors++;
    if ({e, rd} !== {1'b0, 32'hFFFFBEEF}) begin
      miscompares++;
      $display("FAIL half_signed got e=%b rd=%h required 0/ffffbeef", e, rd);
    end
    xact(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rd, e, lat);
    vectors++;
    if ({e, rd} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL half_misalign got e=%b rd=%h required 1/0", e, rd);
    end
    xact(1'b1, 2'b00, 1'b0, 32'h12, 32'h55555555, rd, e, lat);
    vectors++;
    if ({e, rd} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL word_store_misalign got e=%b rd=%h required 1/0", e, rd);
    end
    xact(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, e, lat);
    vectors++;
    if (rd !== 32'h80ADBEEF) begin
      miscompares++;
      $display("FAIL misalign_no_write got %h required 80adbeef", rd);
    end
    xact(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, e, lat);
    vectors++;
    if ({e, rd} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL reserved_type got e=%b rd=%h required 1/0", e, rd);
    end
    xact(1'b1, 2'b01, 1'b0, 32'h12, 32'hAAAA1234, rd, e, lat);
    xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, e, lat);
    vectors++;
    if (rd !== 32'h00001234) begin
      miscompares++;
      $display("FAIL half_store_unsigned got %h required 00001234", rd);
    end
    xact(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, e, lat);
    vectors++;
    if (rd !== 32'h1234BEEF) begin
      miscompares++;
      $display("FAIL half_merge_word got %h required 1234beef", rd);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 2'b10, 1'b0, 32'h1010, 32'h5A, rd, e, lat);
    xact(1'b0, 2'b10, 1'b1, 32'h0010, 32'h0, rd, e, lat);
    vectors++;
    if (rd !== 32'h0000005A) begin
      miscompares++;
      $display("FAIL wrap_byte got %h required 0000005a", rd);
    end
    xact(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, e, lat);
    vectors++;
    if (rd !== 32'h1234BE5A) begin
      miscompares++;
      $display("FAIL wrap_word got %h required 1234be5a", rd);
    end
  endtask

  task automatic test_hold();
    logic [31:0] rd; logic e; int lat; int n;
    logic [31:0] held;
    ReqWrite = 1'b0; ReqType = 2'b00; ReqUnsigned = 1'b0;
    ReqAddr = 32'h10; ReqValid = 1'b1; RspReady = 1'b0;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    n = 0;
    while (!RspValid && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    held = RspRData;
    vectors++;
    if ({RspValid, held} !== {1'b1, 32'h1234BE5A}) begin
      miscompares++;
      $display("FAIL hold_first got v=%b rd=%h required 1/1234be5a",
               RspValid, held);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      if (i == 1) begin
        ReqWrite = 1'b1; ReqAddr = 32'h10;
        ReqWData = 32'hFFFFFFFF; ReqValid = 1'b1;
      end
      if (i == 2) ReqValid = 1'b0;
      vectors++;
      if ({RspValid, ReqReady, RspRData} !== {2'b10, 32'h1234BE5A}) begin
        miscompares++;
        $display("FAIL hold_cycle%0d got v=%b rr=%b rd=%h required 1/0/1234be5a",
                 i, RspValid, ReqReady, RspRData);
      end
    end
    ReqValid = 1'b0;
    RspReady = 1'b1;
    @(posedge Clk); #1;
    vectors++;
    if ({RspValid, RspError, ReqReady, RspRData} !== {3'b001, 32'h0}) begin
      miscompares++;
      $display("FAIL hold_release got v=%b e=%b rr=%b rd=%h required 0/0/1/0",
               RspValid, RspError, ReqReady, RspRData);
    end
    xact(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, e, lat);
    vectors++;
    if (rd !== 32'h1234BE5A) begin
      miscompares++;
      $display("FAIL hold_pulse_ignored got %h required 1234be5a", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 2'b00, 1'b0, 32'h20, 32'h11111111, rd, e, lat);
    ReqWrite = 1'b1; ReqType = 2'b00; ReqAddr = 32'h20;
    ReqWData = 32'h12345678; ReqValid = 1'b1;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    vectors++;
    if ({ReqReady, RspValid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_mid_state got rr=%b v=%b required 1/0",
               ReqReady, RspValid);
    end
    repeat (4) @(posedge Clk);
    #1;
    vectors++;
    if (RspValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_no_rsp got %b required 0", RspValid);
    end
    xact(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, rd, e, lat);
    vectors++;
    if (rd !== 32'h11111111) begin
      miscompares++;
      $display("FAIL reset_mid_no_write got %h required 11111111", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 2'b00, 1'b0, 32'h24, 32'hCAFEF00D, rd, e, lat);
    vectors++;
    if ({ReqReady, RspValid} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_ready got rr=%b v=%b required 1/0",
               ReqReady, RspValid);
    end
    xact(1'b0, 2'b00, 1'b0, 32'h24, 32'h0, rd, e, lat);
    vectors++;
    if ({lat, rd} !== {32'd2, 32'hCAFEF00D}) begin
      miscompares++;
      $display("FAIL b2b_load got lat=%0d rd=%h required 2/cafef00d",
               lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half_errors();
    test_wrap();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
